// File: rtl/sm83_bus_responder.sv
// SM83 memory-interface responder: HRAM, IF and IE served locally, all else via ext req/ack.
// Optional bus timeout enabled by defining BUS_TIMEOUT_EN.
module sm83_bus_responder #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic [7:0]  cpu_rdata,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    input  logic [4:0]  irq_set,
    output logic        int_pending,
    output logic        busy_err,
    output logic        timeout_flag
);

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        EXT_WAIT,
        EXT_DONE
    } state_t;

    state_t state, state_nx;

    logic [7:0] hram [0:126];
    logic [7:0] ie;
    logic [4:0] ifr;

    logic       accept;
    logic       hit_hram;
    logic       hit_if;
    logic       hit_ie;
    logic       hit_int;
    logic [7:0] int_rdata;
    logic       tmo;

    assign accept   = (state == IDLE) && cpu_req;
    assign hit_hram = (cpu_addr[15:7] == 9'h1FF) && (cpu_addr[6:0] != 7'h7F);
    assign hit_ie   = (cpu_addr == 16'hFFFF);
    assign hit_if   = (cpu_addr == 16'hFF0F);
    assign hit_int  = hit_hram || hit_ie || hit_if;

`ifdef BUS_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 8'd0;
        end else if (accept) begin
            tmo_cnt <= 8'd0;
        end else if (state == EXT_WAIT) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Ack in the final cycle takes priority over the forced completion
    assign tmo = (state == EXT_WAIT) && !ext_ack &&
                 (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_nx = hit_int ? RESP : EXT_WAIT;
                end
            end
            RESP:     state_nx = IDLE;
            EXT_WAIT: begin
                if (ext_ack || tmo) begin
                    state_nx = EXT_DONE;
                end
            end
            EXT_DONE: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = (state == RESP) || (state == EXT_DONE);
        ext_req   = (state == EXT_WAIT);
    end

    always_comb begin
        int_rdata = 8'h00;
        unique case (1'b1)
            hit_ie:  int_rdata = ie;
            hit_if:  int_rdata = {3'b111, ifr};
            default: int_rdata = hram[cpu_addr[6:0]];
        endcase
    end

    // HRAM has no reset; contents are undefined until software writes them
    always_ff @(posedge clk) begin
        if (accept && hit_hram && cpu_we) begin
            hram[cpu_addr[6:0]] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata    <= 8'h00;
            ext_we       <= 1'b0;
            ext_addr     <= 16'h0000;
            ext_wdata    <= 8'h00;
            ie           <= 8'h00;
            ifr          <= 5'h00;
            busy_err     <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            if (accept && hit_int && !cpu_we) begin
                cpu_rdata <= int_rdata;
            end else if ((state == EXT_WAIT) && ext_ack && !ext_we) begin
                cpu_rdata <= ext_rdata;
            end else if (tmo) begin
                cpu_rdata <= 8'hFF;
            end
            if (accept && !hit_int) begin
                ext_we    <= cpu_we;
                ext_addr  <= cpu_addr;
                ext_wdata <= cpu_wdata;
            end
            if (accept && hit_ie && cpu_we) begin
                ie <= cpu_wdata;
            end
            // A peripheral request beats a simultaneous software clear
            ifr <= ((accept && hit_if && cpu_we) ? cpu_wdata[4:0] : ifr) | irq_set;
            if (cpu_req && (state != IDLE)) begin
                busy_err <= 1'b1;
            end
            if (tmo) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign int_pending = |(ie[4:0] & ifr);

endmodule
